pb_adr_sequencer: RTL and testbench

PB_ADR_SEQUENCER -- requirements
Module: pb_adr_sequencer

---
 rtl/pb_adr_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pb_adr_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_adr_sequencer.sv
// pb_adr_sequencer: register-programmed pixel-buffer address generator.
// A slave bus programs START, COUNT and STRIDE, then a GO write starts the
// sequence. The block then emits COUNT addresses START, START+STRIDE, ...
// (modulo 2^ADDR_W) over a valid/ready handshake, one address per accepted cycle.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   address[1:0]        register select: 0 START, 1 COUNT, 2 STRIDE, 3 CTRL/STATUS
//   chipselect, write_n slave select and active-low write strobe
//   writedata[31:0]     write data
//   readdata[31:0]      combinational read data; unused bits read as zero
//   out_addr[ADDR_W]    current address (registered)
//   addr_valid          out_addr is valid (registered)
//   addr_ready          consumer accepts out_addr when high together with addr_valid
//   irq                 completion interrupt, present only with PB_ADR_SEQ_IRQ_EN
//
// Build option: define PB_ADR_SEQ_IRQ_EN for the sticky completion interrupt.
module pb_adr_sequencer #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ADDR_W-1:0] out_addr,
  output logic              addr_valid,
  input  logic              addr_ready
`ifdef PB_ADR_SEQ_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [1:0] REG_START  = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_STRIDE = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   start_q, stride_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   stride_sh_q, stride_sh_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                done_set_c;
  logic                irq_pend;

  // Bus write decode; CTRL bits are pulses and are never stored
  logic wr_c, go_c, abort_c, xfer_c;
  assign wr_c    = chipselect && !write_n;
  assign go_c    = wr_c && (address == REG_CTRL) && writedata[0];
  assign abort_c = wr_c && (address == REG_CTRL) && writedata[1];
  assign xfer_c  = valid_q && addr_ready;

  // Programming registers; writes while busy only matter at the next LOAD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q  <= '0;
      count_q  <= '0;
      stride_q <= '0;
    end else if (wr_c) begin
      if (address == REG_START)  start_q  <= writedata[ADDR_W-1:0];
      if (address == REG_COUNT)  count_q  <= writedata[CNT_W-1:0];
      if (address == REG_STRIDE) stride_q <= writedata[ADDR_W-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    stride_sh_d = stride_sh_q;
    done_d      = done_q;
    valid_d     = valid_q;
    done_set_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ABORT in the same write discards GO
        if (go_c && !abort_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_c) begin
          state_d = ST_IDLE;
        end else begin
          cur_d       = start_q;
          rem_d       = count_q;
          stride_sh_d = stride_q;
          if (count_q == '0) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            done_set_c = 1'b1;
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer_c) begin
          cur_d = cur_q + stride_sh_q;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            if (!abort_c) begin
              done_d     = 1'b1;
              done_set_c = 1'b1;
            end
          end
        end
        if (abort_c) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= '0;
      rem_q       <= '0;
      stride_sh_q <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      stride_sh_q <= stride_sh_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
    end
  end

  assign out_addr   = cur_q;
  assign addr_valid = valid_q;

`ifdef PB_ADR_SEQ_IRQ_EN
  // Sticky completion interrupt; a new completion beats a coincident clear
  logic irq_clr_c;
  logic irq_pend_q;
  assign irq_clr_c = wr_c && (address == REG_CTRL) && writedata[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        irq_pend_q <= 1'b0;
    else if (done_set_c) irq_pend_q <= 1'b1;
    else if (irq_clr_c)  irq_pend_q <= 1'b0;
  end

  assign irq_pend = irq_pend_q;
  assign irq      = irq_pend_q;
`else
  logic unused_done_set;
  assign irq_pend        = 1'b0;
  assign unused_done_set = done_set_c;
`endif

  // Upper write-data bits beyond the register widths are ignored
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Combinational read mux
  always_comb begin
    readdata = '0;
    case (address)
      REG_START:  readdata = 32'(start_q);
      REG_COUNT:  readdata = 32'(count_q);
      REG_STRIDE: readdata = 32'(stride_q);
      REG_CTRL:   readdata = {16'(rem_q), 13'd0, irq_pend, done_q, (state_q != ST_IDLE)};
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pb_adr_sequencer.sv
// Randomized self-checking bench for pb_adr_sequencer. Expected addresses are
// computed arithmetically as (START + k*STRIDE) mod 2^ADDR_W; a scoreboard
// counts accepted transfers and predicts status after completion or abort.
module tb_pb_adr_sequencer;

  localparam int unsigned AW = 15;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [AW-1:0] out_addr;
  logic          addr_valid;
  logic          addr_ready;
`ifdef PB_ADR_SEQ_IRQ_EN
  logic          irq;
`endif

  int n_chk;
  int n_pass;

  pb_adr_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_addr   (out_addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready)
`ifdef PB_ADR_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock cycle, optionally with a bus write; called and returns at negedge
  task automatic step(input bit do_wr, input logic [1:0] a, input logic [31:0] d);
    if (do_wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Status check ignores the irq_pending bit (covered separately)
  task automatic chk_status(input string tag, input bit busy, input bit done, input int rem);
    logic [31:0] s;
    rd(2'd3, s);
    check(tag, s & 32'hFFFF_FFFB, {16'(rem), 13'd0, 1'b0, done, busy});
  endtask

  function automatic logic [31:0] exp_addr(input int unsigned st, input int unsigned sd,
                                           input int unsigned k);
    return 32'((st + k * sd) % (32'd1 << AW));
  endfunction

  // Program and run one sequence. abort_after >= 0 aborts after that many transfers.
  // midwr rewrites START and issues a stray GO while the sequence is running.
  task automatic run_job(input int unsigned start, input int unsigned stride,
                         input int unsigned count, input int ready_pct,
                         input int hold_first, input int abort_after, input bit midwr);
    logic [31:0] s;
    int          xfers;
    bit          r;
    bit          fin;
    step(1'b1, 2'd0, start);
    step(1'b1, 2'd2, stride);
    step(1'b1, 2'd1, count);
    step(1'b1, 2'd3, 32'd1);
    check("load_valid", 32'(addr_valid), 32'd0);
    rd(2'd3, s);
    check("load_busy", 32'(s[0]), 32'd1);
    step(1'b0, 2'd0, 32'd0);
    if (count == 0) begin
      check("zero_valid", 32'(addr_valid), 32'd0);
      chk_status("zero_status", 1'b0, 1'b1, 0);
      return;
    end
    xfers = 0;
    fin   = 1'b0;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      check("valid", 32'(addr_valid), 32'd1);
      check("addr", 32'(out_addr), exp_addr(start, stride, xfers));
      if (xfers == abort_after) begin
        addr_ready = 1'b0;
        step(1'b1, 2'd3, 32'd2);
        check("abort_valid", 32'(addr_valid), 32'd0);
        chk_status("abort_status", 1'b0, 1'b0, int'(count) - xfers);
        fin = 1'b1;
      end else begin
        r = (cyc < hold_first) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        addr_ready = r;
        if (midwr && cyc == 1)      step(1'b1, 2'd0, 32'h1234);
        else if (midwr && cyc == 2) step(1'b1, 2'd3, 32'd1);
        else                        step(1'b0, 2'd0, 32'd0);
        if (r) begin
          xfers++;
          if (xfers == int'(count)) begin
            addr_ready = 1'b0;
            check("end_valid", 32'(addr_valid), 32'd0);
            chk_status("done_status", 1'b0, 1'b1, 0);
            fin = 1'b1;
          end
        end
      end
    end
    if (!fin) check("timeout", 32'd1, 32'd0);
    addr_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    int unsigned st, sd, cn;
    int          ab;
    n_chk      = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    addr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), s);
      check("rst_reg", s, 32'd0);
    end
    reset_n = 1'b1;
    step(1'b0, 2'd0, 32'd0);

    // Linear run, wrap-around, stalled consumer
    run_job(32'h10, 1, 4, 100, 0, -1, 1'b0);
    run_job(32'h7FFE, 3, 3, 100, 0, -1, 1'b0);
    run_job(32'h40, 7, 2, 100, 5, -1, 1'b0);

    // Abort after 10 of 100 transfers, then GO+ABORT together while idle
    run_job(32'h100, 2, 100, 100, 0, 10, 1'b0);
    step(1'b1, 2'd3, 32'd3);
    check("goabort_valid", 32'(addr_valid), 32'd0);
    chk_status("goabort_idle", 1'b0, 1'b0, 90);
    step(1'b0, 2'd0, 32'd0);
    check("goabort_valid2", 32'(addr_valid), 32'd0);

    // Zero count completes with done and no address
    run_job(32'h55, 1, 0, 100, 0, -1, 1'b0);
`ifdef PB_ADR_SEQ_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
    step(1'b1, 2'd3, 32'd4);
    check("irq_clr", 32'(irq), 32'd0);
`endif

    // START write and GO while busy: current run unaffected, new START used next time
    run_job(32'h200, 5, 6, 100, 3, -1, 1'b1);
    rd(2'd0, s);
    check("start_rb", s, 32'h1234);
    step(1'b1, 2'd3, 32'd1);
    step(1'b0, 2'd0, 32'd0);
    check("newstart_addr", 32'(out_addr), 32'h1234);
    check("newstart_valid", 32'(addr_valid), 32'd1);
    step(1'b1, 2'd3, 32'd2);

    // Randomized sequences
    for (int j = 0; j < 20; j++) begin
      st = $urandom_range(0, 32767);
      sd = $urandom_range(0, 32767);
      cn = $urandom_range(0, 7);
      ab = (cn != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, cn - 1)) : -1;
      run_job(st, sd, cn, int'($urandom_range(30, 100)), int'($urandom_range(0, 2)), ab, 1'b0);
      rd(2'd1, s);
      check("count_rb", s, 32'(cn));
      rd(2'd2, s);
      check("stride_rb", s, 32'(sd));
    end

    // Reset in the middle of a run
    step(1'b1, 2'd0, 32'h0300);
    step(1'b1, 2'd2, 32'd1);
    step(1'b1, 2'd1, 32'd50);
    step(1'b1, 2'd3, 32'd1);
    addr_ready = 1'b1;
    repeat (5) step(1'b0, 2'd0, 32'd0);
    check("prerst_valid", 32'(addr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_valid", 32'(addr_valid), 32'd0);
    step(1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    rd(2'd3, s);
    check("postrst_status", s, 32'd0);
    rd(2'd0, s);
    check("postrst_start", s, 32'd0);
    repeat (3) step(1'b0, 2'd0, 32'd0);
    check("postrst_valid", 32'(addr_valid), 32'd0);
    addr_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
